fifo_stream_adapter: RTL and testbench



---
 rtl/fifo_stream_adapter_if.sv | 11 +
 rtl/fifo_stream_adapter.sv | 59 +++++
 tb/tb_fifo_stream_adapter.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_stream_adapter_if.sv
// Valid/ready stream carrying FIFO words from the read-side adapter to its consumer.
interface fifo_stream_adapter_if #(
   parameter int DATA_WIDTH = 32
);
   logic                  m_valid;
   logic                  m_ready;
   logic [DATA_WIDTH-1:0] m_data;

   modport master (output m_valid, output m_data, input m_ready);
   modport slave  (input m_valid, input m_data, output m_ready);
endinterface

// File: rtl/fifo_stream_adapter.sv
// Read-side stage for the synchronous FIFO: issues reads, absorbs the one-cycle RAM
// latency and presents words on a valid/ready stream through a 2-entry buffer.
module fifo_stream_adapter #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  fifo_empty,
   output logic                  fifo_read_en,
   input  logic [DATA_WIDTH-1:0] fifo_read_data,
   fifo_stream_adapter_if.master stream,
   output logic [1:0]            buf_count,
   output logic                  idle
);

   logic                  inflight;
   logic                  head;
   logic                  tail;
   logic [DATA_WIDTH-1:0] entry [2];
   logic                  pop;
   logic [2:0]            occupancy;

   assign pop = (buf_count != 2'd0) & stream.m_ready;

   // Slots committed after this edge; issuing a read is safe only if one stays free.
   // The pop term keeps m_ready combinationally in the read path for full throughput.
   assign occupancy    = {1'b0, buf_count} + {2'b00, inflight} - {2'b00, pop};
   assign fifo_read_en = !rst && !fifo_empty && (occupancy < 3'd2);

   assign stream.m_valid = (buf_count != 2'd0);
   assign stream.m_data  = entry[head];
   assign idle           = (buf_count == 2'd0) && !inflight && fifo_empty;

   always_ff @(posedge clk) begin
      // NOTE: state is updated with non-blocking assignments so every read in this
      // block sees the pre-edge value, matching the flop behaviour it describes.
      if (rst) begin
         buf_count <= 2'd0;
         inflight  <= 1'b0;
         head      <= 1'b0;
         tail      <= 1'b0;
         // NOTE: the buffer is only two words, so it is cleared on reset; m_data then
         // shows a defined zero instead of X while m_valid is low.
         entry[0]  <= '0;
         entry[1]  <= '0;
      end else begin
         inflight <= fifo_read_en;
         if (inflight) begin
            entry[tail] <= fifo_read_data;
            tail        <= ~tail;
         end
         if (pop) begin
            head <= ~head;
         end
         buf_count <= buf_count + {1'b0, inflight} - {1'b0, pop};
      end
   end

endmodule

// File: tb/tb_fifo_stream_adapter.sv
// Self-checking bench: a queue-based FIFO stand-in feeds the adapter and a queue
// model of the output buffer predicts every output on each falling edge.
module tb_fifo_stream_adapter;

   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          fifo_empty = 1'b1;
   logic          fifo_read_en;
   logic [DW-1:0] fifo_read_data = '0;
   logic [1:0]    buf_count;
   logic          idle;

   fifo_stream_adapter_if #(.DATA_WIDTH(DW)) s ();

   fifo_stream_adapter #(.DATA_WIDTH(DW)) dut (
      .clk            (clk),
      .rst            (rst),
      .fifo_empty     (fifo_empty),
      .fifo_read_en   (fifo_read_en),
      .fifo_read_data (fifo_read_data),
      .stream         (s),
      .buf_count      (buf_count),
      .idle           (idle)
   );

   always #5 clk = ~clk;

   int n_vec  = 0;
   int n_miss = 0;
   int cyc    = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Stimulus-side controls
   logic          fifo_rst = 1'b0;
   logic          wr_en    = 1'b0;
   logic [DW-1:0] wr_data  = '0;

   // FIFO stand-in: registered empty flag, read data one cycle after the pop.
   logic [DW-1:0] fq[$];
   logic [DW-1:0] sent_q[$];
   logic          take_s = 1'b0, push_s = 1'b0, frst_s = 1'b0;
   logic [DW-1:0] push_d = '0;

   always @(negedge clk) begin
      take_s = fifo_read_en;
      push_s = wr_en;
      push_d = wr_data;
      frst_s = fifo_rst;
   end

   always @(posedge clk) begin
      #1;
      if (frst_s) begin
         fq.delete();
         sent_q.delete();
      end else begin
         if (take_s) begin
            check("read_on_nonempty_fifo", fq.size() != 0, 1'b1);
            if (fq.size() != 0) fifo_read_data = fq.pop_front();
         end
         if (push_s) begin
            fq.push_back(push_d);
            sent_q.push_back(push_d);
         end
      end
      fifo_empty = (fq.size() == 0);
   end

   // Reference model: the output buffer as a queue plus one read-in-flight flag.
   logic [DW-1:0] mq[$];
   logic          minflight = 1'b0;
   logic          exp_valid, exp_pop, exp_rd;
   int            occ;
   logic [DW-1:0] want;
   logic [DW-1:0] pop_data[$];
   int            pop_cyc[$];
   int            rd_cyc[$];

   always @(negedge clk) begin
      cyc++;
      exp_valid = (mq.size() != 0);
      exp_pop   = exp_valid && s.m_ready;
      occ       = mq.size() + int'(minflight) - int'(exp_pop);
      exp_rd    = !rst && !fifo_empty && (occ < 2);

      check("m_valid", s.m_valid, exp_valid);
      check("fifo_read_en", fifo_read_en, exp_rd);
      check("buf_count", buf_count, mq.size());
      check("idle", idle, (mq.size() == 0) && !minflight && fifo_empty);
      check("occupancy_bound", (int'(dut.inflight) + int'(buf_count)) <= 2, 1'b1);
      check("read_while_empty", fifo_read_en && fifo_empty, 1'b0);
      if (exp_valid) check("m_data_head", s.m_data, mq[0]);

      if (exp_pop && !rst) begin
         if (sent_q.size() == 0) begin
            check("order_queue_nonempty", 1'b0, 1'b1);
         end else begin
            want = sent_q.pop_front();
            check("order", s.m_data, want);
         end
         pop_data.push_back(s.m_data);
         pop_cyc.push_back(cyc);
      end
      if (fifo_read_en) rd_cyc.push_back(cyc);

      if (rst) begin
         mq.delete();
         minflight = 1'b0;
      end else begin
         if (exp_pop) void'(mq.pop_front());
         if (minflight) mq.push_back(fifo_read_data);
         minflight = exp_rd;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [DW-1:0] d);
      wr_en   = 1'b1;
      wr_data = d;
      step();
      wr_en   = 1'b0;
   endtask

   task automatic clear_logs();
      pop_data.delete();
      pop_cyc.delete();
      rd_cyc.delete();
   endtask

   task automatic drain(input string name, input int budget);
      bit done = 1'b0;
      s.m_ready = 1'b1;
      repeat (2) step();
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (idle && sent_q.size() == 0) begin
            done = 1'b1;
            break;
         end
      end
      check(name, done, 1'b1);
      step();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      rst       = 1'b1;
      s.m_ready = 1'b0;
      step();

      // Reset held while the FIFO fills with 3 words: no read, nothing valid.
      for (int i = 0; i < 3; i++) push(32'hC0DE_0000 + DW'(i));
      repeat (2) begin
         @(negedge clk);
         check("rst_read_en", fifo_read_en, 1'b0);
         check("rst_m_valid", s.m_valid, 1'b0);
         check("rst_buf_count", buf_count, 2'd0);
         check("rst_m_data", s.m_data, 32'h0);
         check("rst_fifo_holds", fifo_empty, 1'b0);
         step();
      end
      rst = 1'b0;
      drain("drain_after_reset", 40);

      // Single word: one read, valid two cycles later, back to idle.
      clear_logs();
      s.m_ready = 1'b1;
      push(32'hA5A5_0001);
      repeat (8) step();
      @(negedge clk);
      check("single_reads", rd_cyc.size(), 1);
      check("single_pops", pop_data.size(), 1);
      if (pop_data.size() == 1 && rd_cyc.size() == 1) begin
         check("single_data", pop_data[0], 32'hA5A5_0001);
         check("single_latency", pop_cyc[0] - rd_cyc[0], 2);
      end
      check("single_idle", idle, 1'b1);
      step();

      // Streaming 0..15 with the consumer always ready.
      clear_logs();
      for (int i = 0; i < 16; i++) push(DW'(i));
      drain("drain_stream", 40);
      check("stream_reads", rd_cyc.size(), 16);
      check("stream_pops", pop_data.size(), 16);
      for (int i = 0; i < 16 && i < pop_data.size(); i++) begin
         check("stream_data", pop_data[i], DW'(i));
         check("stream_gap", pop_cyc[i] - pop_cyc[0], i);
      end

      // Stall: 8 words queued, consumer not ready for 10 more cycles.
      clear_logs();
      s.m_ready = 1'b0;
      for (int i = 0; i < 8; i++) push(DW'(i));
      repeat (10) step();
      @(negedge clk);
      check("stall_reads", rd_cyc.size(), 2);
      check("stall_buf_count", buf_count, 2'd2);
      check("stall_m_data", s.m_data, 32'h0);
      step();
      clear_logs();
      s.m_ready = 1'b1;
      repeat (12) step();
      check("stall_pops", pop_data.size(), 8);
      check("stall_reads_after", rd_cyc.size(), 6);
      for (int i = 0; i < 8 && i < pop_data.size(); i++) begin
         check("stall_data", pop_data[i], DW'(i));
         check("stall_gap", pop_cyc[i] - pop_cyc[0], i);
      end
      drain("drain_stall", 20);

      // Random writes and random back-pressure over 1000 words.
      clear_logs();
      for (int written = 0; written < 1000; ) begin
         s.m_ready = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 1) == 1) begin
            wr_en   = 1'b1;
            wr_data = $urandom;
            written++;
         end else begin
            wr_en = 1'b0;
         end
         step();
      end
      wr_en = 1'b0;
      drain("drain_random", 3000);
      check("random_pops", pop_data.size(), 1000);

      // Mid-operation reset with a full buffer, then a fresh word.
      s.m_ready = 1'b0;
      for (int i = 0; i < 4; i++) push(32'hDEAD_0000 + DW'(i));
      begin
         bit full = 1'b0;
         for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (buf_count == 2'd2) begin
               full = 1'b1;
               break;
            end
         end
         check("midrst_buffer_full", full, 1'b1);
      end
      step();
      rst      = 1'b1;
      fifo_rst = 1'b1;
      step();
      rst      = 1'b0;
      fifo_rst = 1'b0;
      @(negedge clk);
      check("midrst_m_valid", s.m_valid, 1'b0);
      check("midrst_buf_count", buf_count, 2'd0);
      step();
      clear_logs();
      s.m_ready = 1'b1;
      push(32'h0000_00FF);
      repeat (6) step();
      check("midrst_pops", pop_data.size(), 1);
      if (pop_data.size() != 0) check("midrst_first_word", pop_data[0], 32'h0000_00FF);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
